// File: rtl/writeback_arbiter_if.sv
// Write-back bus bundle: ALU result request, load-return request, and the
// register-file write port with its hazard-tracking outputs.
interface writeback_arbiter_if #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                  alu_valid;
  logic [ADDR_W-1:0]     alu_addr;
  logic [DATA_W-1:0]     alu_data;
  logic                  alu_ready;
  logic                  mem_valid;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_data;
  logic                  mem_ready;
  logic                  we3;
  logic [ADDR_W-1:0]     wa3;
  logic [DATA_W-1:0]     wd3;
  logic [(1<<ADDR_W)-1:0] pending;
  logic [CNT_W-1:0]      fifo_count;

  // Arbiter side
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    output alu_ready, mem_ready, we3, wa3, wd3, pending, fifo_count
  );

  // Source / register-file side
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
    input  alu_ready, mem_ready, we3, wa3, wd3, pending, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges the unbuffered ALU result path (high priority) and the FIFO-buffered
// load-return path onto the single register-file write port. A starvation
// counter forces the FIFO head through after STARVE_MAX consecutive ALU wins,
// and a pending vector flags every register with a write still in flight.
module writeback_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             rst,
  writeback_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NREG  = 1 << ADDR_W;
  localparam int SC_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam int ENT_W = ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
  localparam logic [SC_W-1:0]  STARVE_LIM = SC_W'(STARVE_MAX);

  // Saturating increment for the starvation counter.
  function automatic logic [SC_W-1:0] sat_inc(input logic [SC_W-1:0] v);
    return (v == STARVE_LIM) ? v : v + SC_W'(1);
  endfunction

  // Load-return FIFO state
  logic [ENT_W-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [SC_W-1:0]  starve_cnt;

  // Arbitration results
  logic              fifo_empty, fifo_full, force_fifo;
  logic              alu_win, fifo_win, push, pop;
  logic [ENT_W-1:0]  head;

  // Stage p0: combinational winner; stage p1: registered write port
  logic              vld_p0, vld_p1;
  logic [ADDR_W-1:0] addr_p0, addr_p1;
  logic [DATA_W-1:0] data_p0, data_p1;

  logic [NREG-1:0]   pend;

  assign head       = fifo_mem[rd_ptr];
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign force_fifo = (starve_cnt == STARVE_LIM) && !fifo_empty;

  // Pick the winner: ALU unless starvation forces the FIFO head through.
  always_comb begin
    alu_win  = 1'b0;
    fifo_win = 1'b0;
    vld_p0   = 1'b0;
    addr_p0  = addr_p1;
    data_p0  = data_p1;
    if (bus.alu_valid && !force_fifo) begin
      alu_win = 1'b1;
      vld_p0  = 1'b1;
      addr_p0 = bus.alu_addr;
      data_p0 = bus.alu_data;
    end else if (!fifo_empty) begin
      fifo_win = 1'b1;
      vld_p0   = 1'b1;
      addr_p0  = head[ENT_W-1 -: ADDR_W];
      data_p0  = head[DATA_W-1:0];
    end
  end

  // A full FIFO refuses pushes even when it pops in the same cycle.
  assign push = bus.mem_valid && !fifo_full;
  assign pop  = fifo_win;

  // FIFO pointers, occupancy, starvation counter and the write-port register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      starve_cnt <= '0;
      vld_p1     <= 1'b0;
      addr_p1    <= '0;
      data_p1    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      starve_cnt <= (alu_win && !fifo_empty) ? sat_inc(starve_cnt) : '0;
      // Stage p1 boundary: winner registered onto the write port
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= data_p0;
      end
    end
  end

  // FIFO storage; contents only matter once counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {bus.mem_addr, bus.mem_data};
  end

  // Pending vector: every occupied FIFO slot plus the write on the port.
  always_comb begin
    logic [PTR_W-1:0] slot_off;
    pend     = '0;
    slot_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PTR_W'(i) - rd_ptr;
      if ({1'b0, slot_off} < count) pend[fifo_mem[i][ENT_W-1 -: ADDR_W]] = 1'b1;
    end
    if (vld_p1) pend[addr_p1] = 1'b1;
  end

  assign bus.alu_ready  = !force_fifo;
  assign bus.mem_ready  = !fifo_full;
  assign bus.we3        = vld_p1;
  assign bus.wa3        = addr_p1;
  assign bus.wd3        = data_p1;
  assign bus.pending    = pend;
  assign bus.fifo_count = count;

endmodule
